// File: rtl/rx_len_type_decoder.sv
// Receive header decoder: extracts the length/type field (with 802.1Q detection)
// from the first frame words and produces word/byte counts for the data counter.
module rx_len_type_decoder #(
    parameter logic [12:0] MAX_WORDS   = 13'h1FFF,
    parameter int          MIN_PAYLOAD = 46
) (
    input  logic        rxclk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        frame_end,
    input  logic [63:0] rxd64,
    input  logic        end_data_cnt,
    output logic [12:0] integer_cnt,
    output logic [12:0] small_integer_cnt,
    output logic [2:0]  frac_cnt,
    output logic [2:0]  small_frac_cnt,
    output logic        small_frame,
    output logic        tagged_frame,
    output logic        start_data_cnt,
    output logic        start_tagged_cnt,
    output logic        length_valid,
    output logic        length_err
);

    typedef enum logic [2:0] {
        IDLE,
        HDR1,
        HDR2,
        CNT,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [12:0] integerCnt_q, integerCnt_d;
    logic [12:0] smallIntegerCnt_q, smallIntegerCnt_d;
    logic [2:0]  fracCnt_q, fracCnt_d;
    logic [2:0]  smallFracCnt_q, smallFracCnt_d;
    logic        smallFrame_q, smallFrame_d;
    logic        taggedFrame_q, taggedFrame_d;
    logic        startData_q, startData_d;
    logic        startTagged_q, startTagged_d;
    logic        lengthValid_q, lengthValid_d;
    logic        lengthErr_q, lengthErr_d;

    logic [15:0] lenField;
    logic        tagNow;
    logic [15:0] minPay;
    logic [15:0] baseOff;
    logic [15:0] wordSub;
    logic [15:0] padLen;
    logic [15:0] padSum;
    logic [15:0] realSum;
    logic [15:0] padWords;
    logic [15:0] realWords;
    logic        lenOk;
    logic        unusedBits;

    // Tagged frames count data from word3 (4 extra header bytes), untagged from word2.
    always_comb begin
        tagNow    = (state_q == HDR2);
        lenField  = tagNow ? {rxd64[7:0], rxd64[15:8]} : {rxd64[39:32], rxd64[47:40]};
        minPay    = tagNow ? 16'(MIN_PAYLOAD - 4) : 16'(MIN_PAYLOAD);
        baseOff   = tagNow ? 16'd18 : 16'd14;
        wordSub   = tagNow ? 16'd3 : 16'd2;
        padLen    = (lenField < minPay) ? minPay : lenField;
        padSum    = baseOff + padLen;
        realSum   = baseOff + lenField;
        padWords  = (padSum >> 3) - wordSub;
        realWords = ((realSum >> 3) < wordSub) ? 16'd0 : (realSum >> 3) - wordSub;
        lenOk     = (lenField <= 16'd1500);
    end

    assign unusedBits = ^{rxd64[63:48], rxd64[31:16], padWords[15:13], realWords[15:13]};

    always_ff @(posedge rxclk) begin
        if (reset) begin
            state_q           <= IDLE;
            integerCnt_q      <= '0;
            smallIntegerCnt_q <= '0;
            fracCnt_q         <= '0;
            smallFracCnt_q    <= '0;
            smallFrame_q      <= 1'b0;
            taggedFrame_q     <= 1'b0;
            startData_q       <= 1'b0;
            startTagged_q     <= 1'b0;
            lengthValid_q     <= 1'b0;
            lengthErr_q       <= 1'b0;
        end else begin
            state_q           <= state_d;
            integerCnt_q      <= integerCnt_d;
            smallIntegerCnt_q <= smallIntegerCnt_d;
            fracCnt_q         <= fracCnt_d;
            smallFracCnt_q    <= smallFracCnt_d;
            smallFrame_q      <= smallFrame_d;
            taggedFrame_q     <= taggedFrame_d;
            startData_q       <= startData_d;
            startTagged_q     <= startTagged_d;
            lengthValid_q     <= lengthValid_d;
            lengthErr_q       <= lengthErr_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        integerCnt_d      = integerCnt_q;
        smallIntegerCnt_d = smallIntegerCnt_q;
        fracCnt_d         = fracCnt_q;
        smallFracCnt_d    = smallFracCnt_q;
        smallFrame_d      = smallFrame_q;
        taggedFrame_d     = taggedFrame_q;
        startData_d       = startData_q;
        startTagged_d     = startTagged_q;
        lengthValid_d     = lengthValid_q;
        lengthErr_d       = 1'b0;

        // A new frame_start always wins, aborting whatever frame was in flight.
        if (frame_start) begin
            state_d           = HDR1;
            integerCnt_d      = '0;
            smallIntegerCnt_d = '0;
            fracCnt_d         = '0;
            smallFracCnt_d    = '0;
            smallFrame_d      = 1'b0;
            taggedFrame_d     = 1'b0;
            startData_d       = 1'b0;
            startTagged_d     = 1'b0;
            lengthValid_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                HDR1, HDR2: begin
                    if (frame_end) begin
                        lengthErr_d = 1'b1;
                        state_d     = IDLE;
                    end else if ((state_q == HDR1) && (lenField == 16'h8100)) begin
                        state_d = HDR2;
                    end else begin
                        lengthValid_d     = lenOk;
                        smallFrame_d      = lenOk && (lenField < minPay);
                        integerCnt_d      = lenOk ? padWords[12:0] : MAX_WORDS;
                        smallIntegerCnt_d = lenOk ? realWords[12:0] : MAX_WORDS;
                        fracCnt_d         = lenOk ? padSum[2:0] : 3'd0;
                        smallFracCnt_d    = lenOk ? realSum[2:0] : 3'd0;
                        taggedFrame_d     = tagNow;
                        startData_d       = 1'b1;
                        startTagged_d     = tagNow;
                        state_d           = CNT;
                    end
                end
                CNT: begin
                    if (frame_end) begin
                        lengthErr_d   = lengthValid_q && !end_data_cnt;
                        startData_d   = 1'b0;
                        startTagged_d = 1'b0;
                        state_d       = IDLE;
                    end else if (end_data_cnt) begin
                        startData_d   = 1'b0;
                        startTagged_d = 1'b0;
                        state_d       = DONE;
                    end
                end
                DONE: begin
                    if (frame_end) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign integer_cnt       = integerCnt_q;
    assign small_integer_cnt = smallIntegerCnt_q;
    assign frac_cnt          = fracCnt_q;
    assign small_frac_cnt    = smallFracCnt_q;
    assign small_frame       = smallFrame_q;
    assign tagged_frame      = taggedFrame_q;
    assign start_data_cnt    = startData_q;
    assign start_tagged_cnt  = startTagged_q;
    assign length_valid      = lengthValid_q;
    assign length_err        = lengthErr_q;

endmodule

// File: tb/tb_rx_len_type_decoder.sv
// Directed self-checking bench for rx_len_type_decoder with hand-computed expectations.
module tb_rx_len_type_decoder;

    logic        rxclk;
    logic        reset;
    logic        frame_start;
    logic        frame_end;
    logic [63:0] rxd64;
    logic        end_data_cnt;
    logic [12:0] integer_cnt;
    logic [12:0] small_integer_cnt;
    logic [2:0]  frac_cnt;
    logic [2:0]  small_frac_cnt;
    logic        small_frame;
    logic        tagged_frame;
    logic        start_data_cnt;
    logic        start_tagged_cnt;
    logic        length_valid;
    logic        length_err;

    int checkCount = 0;
    int failCount  = 0;

    rx_len_type_decoder dut (
        .rxclk             (rxclk),
        .reset             (reset),
        .frame_start       (frame_start),
        .frame_end         (frame_end),
        .rxd64             (rxd64),
        .end_data_cnt      (end_data_cnt),
        .integer_cnt       (integer_cnt),
        .small_integer_cnt (small_integer_cnt),
        .frac_cnt          (frac_cnt),
        .small_frac_cnt    (small_frac_cnt),
        .small_frame       (small_frame),
        .tagged_frame      (tagged_frame),
        .start_data_cnt    (start_data_cnt),
        .start_tagged_cnt  (start_tagged_cnt),
        .length_valid      (length_valid),
        .length_err        (length_err)
    );

    initial rxclk = 1'b0;
    always #5 rxclk = ~rxclk;

    function automatic logic [63:0] word1(input logic [15:0] lt);
        return {16'hA5A5, lt[7:0], lt[15:8], 32'h5A5A_5A5A};
    endfunction

    function automatic logic [63:0] word2(input logic [15:0] len);
        return {48'h1234_5678_9ABC, len[7:0], len[15:8]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the clock edge that consumes them.
    task automatic applyStimulus(input logic fs, input logic fe, input logic edc, input logic [63:0] data);
        frame_start  = fs;
        frame_end    = fe;
        end_data_cnt = edc;
        rxd64        = data;
        @(posedge rxclk);
        #1;
        frame_start  = 1'b0;
        frame_end    = 1'b0;
        end_data_cnt = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_int"}, 32'(integer_cnt), 32'd0);
        checkOutput({tag, "_sint"}, 32'(small_integer_cnt), 32'd0);
        checkOutput({tag, "_frac"}, 32'(frac_cnt), 32'd0);
        checkOutput({tag, "_sfrac"}, 32'(small_frac_cnt), 32'd0);
        checkOutput({tag, "_flags"}, 32'({small_frame, tagged_frame, start_data_cnt,
                                          start_tagged_cnt, length_valid, length_err}), 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        frame_start  = 1'b0;
        frame_end    = 1'b0;
        end_data_cnt = 1'b0;
        rxd64        = '0;
        repeat (2) @(posedge rxclk);
        #1;
        checkAllZero("reset");
        reset = 1'b0;
        applyStimulus(0, 0, 0, 64'h0);

        // Untagged L=100
        applyStimulus(1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("t1_hdr_start", 32'(start_data_cnt), 32'd0);
        applyStimulus(0, 0, 0, word1(16'd100));
        checkOutput("t1_int", 32'(integer_cnt), 32'd12);
        checkOutput("t1_frac", 32'(frac_cnt), 32'd2);
        checkOutput("t1_sint", 32'(small_integer_cnt), 32'd12);
        checkOutput("t1_sfrac", 32'(small_frac_cnt), 32'd2);
        checkOutput("t1_flags", 32'({small_frame, tagged_frame, length_valid, start_data_cnt, start_tagged_cnt}), 32'b00110);
        applyStimulus(0, 0, 1, 64'h0);
        checkOutput("t1_start_drop", 32'(start_data_cnt), 32'd0);
        checkOutput("t1_hold_int", 32'(integer_cnt), 32'd12);
        applyStimulus(0, 1, 0, 64'h0);
        checkOutput("t1_done_err", 32'(length_err), 32'd0);

        // Untagged L=10 (runt payload, padded)
        applyStimulus(1, 0, 0, 64'h0);
        applyStimulus(0, 0, 0, word1(16'd10));
        checkOutput("t2_int", 32'(integer_cnt), 32'd5);
        checkOutput("t2_frac", 32'(frac_cnt), 32'd4);
        checkOutput("t2_sint", 32'(small_integer_cnt), 32'd1);
        checkOutput("t2_sfrac", 32'(small_frac_cnt), 32'd0);
        checkOutput("t2_small", 32'(small_frame), 32'd1);
        applyStimulus(0, 1, 1, 64'h0);
        checkOutput("t2_end_err", 32'(length_err), 32'd0);

        // Tagged, L=64
        applyStimulus(1, 0, 0, 64'h0);
        applyStimulus(0, 0, 0, word1(16'h8100));
        checkOutput("t3_hdr2_start", 32'(start_data_cnt), 32'd0);
        checkOutput("t3_hdr2_tag", 32'(tagged_frame), 32'd0);
        applyStimulus(0, 0, 0, word2(16'd64));
        checkOutput("t3_tag", 32'(tagged_frame), 32'd1);
        checkOutput("t3_int", 32'(integer_cnt), 32'd7);
        checkOutput("t3_frac", 32'(frac_cnt), 32'd2);
        checkOutput("t3_sint", 32'(small_integer_cnt), 32'd7);
        checkOutput("t3_starts", 32'({start_data_cnt, start_tagged_cnt}), 32'b11);
        checkOutput("t3_small", 32'(small_frame), 32'd0);
        applyStimulus(0, 1, 1, 64'h0);
        checkOutput("t3_end_err", 32'(length_err), 32'd0);
        checkOutput("t3_end_starts", 32'({start_data_cnt, start_tagged_cnt}), 32'b00);

        // Tagged, L=0: padded to 42, real count saturates at zero
        applyStimulus(1, 0, 0, 64'h0);
        applyStimulus(0, 0, 0, word1(16'h8100));
        applyStimulus(0, 0, 0, word2(16'd0));
        checkOutput("t3b_int", 32'(integer_cnt), 32'd4);
        checkOutput("t3b_frac", 32'(frac_cnt), 32'd4);
        checkOutput("t3b_sint", 32'(small_integer_cnt), 32'd0);
        checkOutput("t3b_sfrac", 32'(small_frac_cnt), 32'd2);
        checkOutput("t3b_small", 32'(small_frame), 32'd1);
        applyStimulus(0, 1, 1, 64'h0);

        // Type frame 0x0800
        applyStimulus(1, 0, 0, 64'h0);
        applyStimulus(0, 0, 0, word1(16'h0800));
        checkOutput("t4_valid", 32'(length_valid), 32'd0);
        checkOutput("t4_int", 32'(integer_cnt), 32'h1FFF);
        checkOutput("t4_sint", 32'(small_integer_cnt), 32'h1FFF);
        checkOutput("t4_fracs", 32'({frac_cnt, small_frac_cnt}), 32'd0);
        checkOutput("t4_start", 32'(start_data_cnt), 32'd1);
        applyStimulus(0, 0, 0, 64'h0);
        applyStimulus(0, 1, 0, 64'h0);
        checkOutput("t4_cnt_end_err", 32'(length_err), 32'd0);
        checkOutput("t4_cnt_end_start", 32'(start_data_cnt), 32'd0);
        applyStimulus(1, 0, 0, 64'h0);
        applyStimulus(0, 1, 0, word1(16'd100));
        checkOutput("t4_hdr1_err", 32'(length_err), 32'd1);
        checkOutput("t4_hdr1_start", 32'(start_data_cnt), 32'd0);
        applyStimulus(0, 0, 0, 64'h0);
        checkOutput("t4_err_pulse", 32'(length_err), 32'd0);

        // Just above the length limit is a type
        applyStimulus(1, 0, 0, 64'h0);
        applyStimulus(0, 0, 0, word1(16'd1501));
        checkOutput("t4b_valid", 32'(length_valid), 32'd0);
        checkOutput("t4b_int", 32'(integer_cnt), 32'h1FFF);
        applyStimulus(0, 1, 1, 64'h0);

        // Runt: L=1500, frame_end at t+5 before end_data_cnt
        applyStimulus(1, 0, 0, 64'h0);
        applyStimulus(0, 0, 0, word1(16'd1500));
        checkOutput("t5_valid", 32'(length_valid), 32'd1);
        checkOutput("t5_int", 32'(integer_cnt), 32'd187);
        checkOutput("t5_frac", 32'(frac_cnt), 32'd2);
        applyStimulus(0, 0, 0, 64'h0);
        applyStimulus(0, 0, 0, 64'h0);
        applyStimulus(0, 1, 0, 64'h0);
        checkOutput("t5_err", 32'(length_err), 32'd1);
        checkOutput("t5_start", 32'(start_data_cnt), 32'd0);
        applyStimulus(0, 0, 0, 64'h0);
        checkOutput("t5_err_pulse", 32'(length_err), 32'd0);
        applyStimulus(0, 0, 1, 64'h0);
        checkOutput("t5_idle_start", 32'(start_data_cnt), 32'd0);

        // Restart mid-CNT
        applyStimulus(1, 0, 0, 64'h0);
        applyStimulus(0, 0, 0, word1(16'd100));
        checkOutput("t6_pre_start", 32'(start_data_cnt), 32'd1);
        applyStimulus(1, 0, 0, 64'h0);
        checkAllZero("t6_abort");
        applyStimulus(0, 0, 0, word1(16'd10));
        checkOutput("t6_restart_int", 32'(integer_cnt), 32'd5);
        checkOutput("t6_restart_start", 32'(start_data_cnt), 32'd1);

        // Reset mid-HDR2
        applyStimulus(1, 0, 0, 64'h0);
        applyStimulus(0, 0, 0, word1(16'h8100));
        reset = 1'b1;
        applyStimulus(0, 0, 0, word2(16'd64));
        checkAllZero("t6_reset");
        reset = 1'b0;
        applyStimulus(0, 0, 0, word2(16'd64));
        checkAllZero("t6_post_reset");
        applyStimulus(0, 1, 0, 64'h0);
        checkOutput("t6_idle_end_err", 32'(length_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/rx_len_type_decoder.md
Name: rx_len_type_decoder

Overview:
Receive-side header decoder between the XGMII lane aligner and the 64-bit data-field counter stage.
- Watches the first three 64-bit words of each frame and extracts the length/type field, including 802.1Q detection.
- Computes the word counts (integer_cnt, small_integer_cnt), fractional-byte counts and the small/tagged flags.
- Generates start_data_cnt / start_tagged_cnt for the downstream counter.
- Consumes end_data_cnt to close the data field, and flags length/frame-size mismatches.

Parameters:
MAX_WORDS, 13'h1FFF, integer_cnt value used when the field is a type (not a length), i.e. count until frame_end.
MIN_PAYLOAD, 46, minimum untagged data-field bytes; tagged minimum is MIN_PAYLOAD-4.

Ports:
rxclk  in  1  receive clock
reset  in  1  synchronous, active-high reset
frame_start  in  1  pulse: word0 (bytes 0-7, after SFD) present on rxd64 this cycle
frame_end  in  1  pulse: last word of the frame (terminate seen) present this cycle
rxd64  in  64  frame data, byte n of word at bits [8n+7:8n] (lane 0 = lowest byte)
end_data_cnt  in  1  from the counter stage: data field (64-bit aligned part) complete
integer_cnt  out  13  64-bit words of the padded data field, counted from the first counted word
small_integer_cnt  out  13  words of the real (unpadded) data field
frac_cnt  out  3  padded data-field bytes mod 8
small_frac_cnt  out  3  real data-field bytes mod 8
small_frame  out  1  length field < minimum payload
tagged_frame  out  1  TPID 0x8100 detected
start_data_cnt  out  1  enable for the data counter
start_tagged_cnt  out  1  enable for the tagged counter
length_valid  out  1  length/type field is a length (≤1500)
length_err  out  1  one-cycle pulse: frame_end/data-field end mismatch

Behaviour:
- Reset (synchronous, active-high, rxclk): state IDLE; all outputs 0.
- Words arrive on consecutive cycles from frame_start to frame_end with no gaps.
- Field LT = {byte12, byte13} of word1 (rxd64[39:32] is the high byte, rxd64[47:40] the low byte).
- FSM states: IDLE, HDR1, HDR2, CNT, DONE.
- IDLE: frame_start → HDR1.
- HDR1 (word1 on bus): register LT.
  - If LT == 16'h8100 → HDR2.
  - Otherwise decode L = LT, untagged, → CNT.
- HDR2 (word2 on bus): L = {byte16, byte17} = {rxd64[7:0], rxd64[15:8]}; tagged_frame = 1; → CNT.
- Decoded outputs are registered and valid from the first CNT cycle. They hold until the next frame_start or reset.
- Untagged arithmetic (data counted from word2):
  - P = max(L, MIN_PAYLOAD)
  - integer_cnt = ((14+P)>>3) - 2
  - frac_cnt = (14+P)&7
  - small_integer_cnt = sat0(((14+L)>>3) - 2)
  - small_frac_cnt = (14+L)&7
- Tagged arithmetic (data counted from word3):
  - P = max(L, MIN_PAYLOAD-4)
  - integer_cnt = ((18+P)>>3) - 3
  - small values use 18+L, same form; frac = (18+x)&7.
- sat0 clamps a negative result to 0. All arithmetic is 16-bit internally, truncated to 13 bits.
- small_frame = length_valid & (L < P).
- If L > 1500: length_valid = 0, small_frame = 0, integer_cnt = MAX_WORDS, small_integer_cnt = MAX_WORDS, fracs = 0.
- CNT:
  - Untagged: start_data_cnt = 1.
  - Tagged: start_data_cnt = 1 and start_tagged_cnt = 1.
  - end_data_cnt → DONE; start_* drop the next cycle.
- DONE: start_* = 0; frame_end → IDLE.
- Length error:
  - frame_end while in HDR1, HDR2 or CNT: pulse length_err if length_valid (or if still in a header state), then → IDLE.
  - frame_end and end_data_cnt in the same CNT cycle: normal, no error, → IDLE.
- frame_start in any non-IDLE state aborts the current frame and restarts at HDR1. Outputs are cleared that cycle, except length_err = 0.
- Latency: frame_start at cycle t → start_data_cnt high at t+2 (untagged) or t+3 (tagged).

Test Plan:
1. Untagged, L=100 (0x0064) → at t+2: integer_cnt=12, frac_cnt=2, small_integer_cnt=12, small_frame=0, tagged_frame=0, length_valid=1, start_data_cnt=1; drive end_data_cnt → start_data_cnt=0 the next cycle.
2. Untagged, L=10 → integer_cnt=5, frac_cnt=4, small_integer_cnt=1, small_frac_cnt=0, small_frame=1.
3. Tagged: word1 LT=0x8100, word2 L=64 → at t+3: tagged_frame=1, integer_cnt=7, frac_cnt=2, start_tagged_cnt=1, start_data_cnt=1, small_frame=0.
4. Type frame, LT=0x0800 → length_valid=0, integer_cnt=13'h1FFF; frame_end in CNT → length_err=0; frame_end in HDR1 → length_err=1.
5. Runt: L=1500 with frame_end at t+5 before end_data_cnt → length_err pulses for 1 cycle, FSM returns to IDLE, start_data_cnt=0.
6. Second frame_start mid-CNT, and reset asserted mid-HDR2 → restart at HDR1 with outputs cleared; after reset all outputs are 0 and frame_end is ignored in IDLE.
